// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port read arbiter with registered grant and tagged pipelined return
module mem_arbiter #(
  parameter int MEM_LATENCY = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             req0,
  input  logic [7:0]       addr0,
  output logic             gnt0,
  output logic             rvalid0,
  input  logic             req1,
  input  logic [7:0]       addr1,
  output logic             gnt1,
  output logic             rvalid1,
  output logic [31:0]      rdata,
  output logic [7:0]       mem_addr,
  input  logic [31:0]      mem_data,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);
  logic                 last;
  logic                 w0, w1;
  logic [MEM_LATENCY:0] pv, pid;
  // winner this edge: a lone requester wins, a tie goes to the port that was not granted last
  always_comb begin
    w0 = en & req0 & (~req1 | last);
    w1 = en & req1 & (~req0 | ~last);
  end
  // grant, address and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      last     <= 1'b1;
      mem_addr <= 8'h00;
    end else begin
      gnt0 <= w0;
      gnt1 <= w1;
      if (w0 | w1) begin
        last     <= w1;
        mem_addr <= w1 ? addr1 : addr0;
      end
    end
  end
  // tagged return pipeline; keeps shifting while en is low so granted reads return on time
  always_ff @(posedge clk) begin
    if (rst) begin
      pv      <= '0;
      pid     <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata   <= 32'h0;
    end else begin
      pv[0]  <= w0 | w1;
      pid[0] <= w1;
      for (int i = 1; i <= MEM_LATENCY; i++) begin
        pv[i]  <= pv[i-1];
        pid[i] <= pid[i-1];
      end
      rvalid0 <= pv[MEM_LATENCY] & ~pid[MEM_LATENCY];
      rvalid1 <= pv[MEM_LATENCY] & pid[MEM_LATENCY];
      if (pv[MEM_LATENCY]) rdata <= mem_data;
    end
  end
  // saturating per-port grant counters
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (w0 && !(&gnt_cnt0)) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (w1 && !(&gnt_cnt1)) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a queue-based reference model and per-cycle output compare
module tb_mem_arbiter;
  localparam int L = 1;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 0, rst = 1, en = 1;
  logic req0 = 0, req1 = 0;
  logic [7:0] addr0 = 0, addr1 = 0;
  logic gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata, mem_data = 0;
  logic [7:0] mem_addr;
  logic [CW-1:0] gnt_cnt0, gnt_cnt1;
  int errors = 0, checks = 0;

  mem_arbiter #(.MEM_LATENCY(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_data(mem_data),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [7:0] a);
    return {a, 8'hA5, ~a, a ^ 8'h3C};
  endfunction

  // ROM with one cycle of latency
  always @(posedge clk) mem_data <= rom(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: grants by rule, returns as timestamped queue entries
  typedef struct {int due; bit id; logic [31:0] d;} ret_t;
  ret_t q[$];
  int cyc = 0, c0 = 0, c1 = 0;
  bit last = 1, live = 0, m_g0, m_g1, m_rv0, m_rv1, win;
  logic [7:0] m_addr = 0;
  logic [31:0] m_rdata = 0;

  always @(posedge clk) begin
    cyc++;
    live = 1;
    m_g0 = 0; m_g1 = 0; m_rv0 = 0; m_rv1 = 0;
    if (rst) begin
      q.delete();
      c0 = 0; c1 = 0; last = 1; m_addr = 0; m_rdata = 0;
    end else begin
      if (q.size() > 0 && q[0].due == cyc) begin
        if (q[0].id) m_rv1 = 1; else m_rv0 = 1;
        m_rdata = q[0].d;
        void'(q.pop_front());
      end
      if (en && (req0 || req1)) begin
        win = (req0 && req1) ? !last : req1;
        last = win;
        m_addr = win ? addr1 : addr0;
        if (win) begin m_g1 = 1; if (c1 < CMAX) c1++; end
        else begin m_g0 = 1; if (c0 < CMAX) c0++; end
        q.push_back('{cyc + L + 1, win, rom(m_addr)});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (live) begin
      chk("gnt0", gnt0, m_g0);
      chk("gnt1", gnt1, m_g1);
      chk("rvalid0", rvalid0, m_rv0);
      chk("rvalid1", rvalid1, m_rv1);
      chk("rdata", rdata, m_rdata);
      chk("mem_addr", mem_addr, m_addr);
      chk("gnt_cnt0", gnt_cnt0, c0);
      chk("gnt_cnt1", gnt_cnt1, c1);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1; req0 = 0; req1 = 0; en = 1;
    step(2);
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n0, n1;
    step(2);
    chk("reset_rdata", rdata, 32'h0);
    chk("reset_cnt0", gnt_cnt0, 0);
    rst = 0;
    // single port 0 read
    req0 = 1; addr0 = 8'h05;
    step(1);
    chk("t1_gnt0", gnt0, 1);
    chk("t1_addr", mem_addr, 8'h05);
    req0 = 0;
    step(2);
    chk("t1_rvalid0", rvalid0, 1);
    chk("t1_rdata", rdata, 32'h05A5FA39);
    // both ports held six cycles
    do_reset();
    req0 = 1; req1 = 1; addr0 = 8'h10; addr1 = 8'h85;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("t2_gnt0", gnt0, (i % 2) == 0);
      chk("t2_addr", mem_addr, (i % 2) == 0 ? 8'h10 : 8'h85);
    end
    req0 = 0; req1 = 0;
    step(3);
    chk("t2_cnt0", gnt_cnt0, 3);
    chk("t2_cnt1", gnt_cnt1, 3);
    // port 1 cancels in the cycle port 0 wins
    do_reset();
    req0 = 1; req1 = 1; addr0 = 8'h01; addr1 = 8'h81;
    step(1);
    chk("t3_gnt0", gnt0, 1);
    req0 = 0; req1 = 0;
    n1 = 0;
    for (int i = 0; i < 4; i++) begin step(1); n1 += int'(rvalid1) + int'(gnt1); end
    chk("t3_no_port1", n1, 0);
    chk("t3_cnt1", gnt_cnt1, 0);
    // enable low with port 0 pending
    req0 = 1; addr0 = 8'h22;
    step(1);
    chk("t4_gnt_before", gnt0, 1);
    en = 0;
    n0 = 0; n1 = 0;
    for (int i = 0; i < 4; i++) begin step(1); n0 += int'(gnt0); n1 += int'(rvalid0); end
    chk("t4_no_gnt", n0, 0);
    chk("t4_rvalid_on_time", n1, 1);
    en = 1;
    step(1);
    chk("t4_gnt_after", gnt0, 1);
    req0 = 0;
    step(3);
    // reset while a port 1 read is in flight
    req1 = 1; addr1 = 8'h80;
    step(1);
    chk("t5_gnt1", gnt1, 1);
    req1 = 0; rst = 1;
    step(1);
    rst = 0;
    chk("t5_cnt0", gnt_cnt0, 0);
    chk("t5_cnt1", gnt_cnt1, 0);
    chk("t5_addr", mem_addr, 0);
    chk("t5_rdata", rdata, 0);
    n1 = 0;
    for (int i = 0; i < 4; i++) begin step(1); n1 += int'(rvalid1); end
    chk("t5_no_rvalid1", n1, 0);
    req0 = 1; req1 = 1; addr0 = 8'h33; addr1 = 8'hC4;
    step(1);
    chk("t5_first_gnt0", gnt0, 1);
    chk("t5_first_gnt1", gnt1, 0);
    req0 = 0; req1 = 0;
    step(3);
    // counter saturation
    do_reset();
    req0 = 1; addr0 = 8'h7F;
    step(20);
    req0 = 0;
    step(3);
    chk("t6_cnt0_sat", gnt_cnt0, 15);
    chk("t6_rdata", rdata, 32'h7FA58043);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
